pmc_shift_sequencer: RTL and testbench
======================================

Name: pmc_shift_sequencer

Overview:
Hardware sequencer for the pixel-matrix serial shift path. Generates the shift/load strobe (sh) and shift clock (pclk) sequence that drives the PMC transmitter/receiver shift chains: optional parallel-load pulse, then N shift clocks at a programmable rate. Removes per-bit bit-banging from the PMCC program. Arbitrates the sh/pclk lines between itself and the PMCC: the sequencer owns them while busy, the PMCC owns them otherwise.

Parameters:
CNT_W, 16, width of shift-count and remaining-count fields
DIV_W, 8, width of pclk half-period field (in clk cycles)

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
start  input  1  single-cycle request to run one sequence
abort  input  1  single-cycle request to terminate a running sequence
load_en  input  1  sampled at start; 1 = perform parallel-load pulse before shifting
shift_count  input  CNT_W  number of shift pclk pulses; sampled at start
half_period  input  DIV_W  pclk high time and low time in clk cycles; sampled at start; 0 treated as 1
pmcc_busy  input  1  PMCC is running a program; blocks start
pmcc_sh  input  1  sh driven by PMCC
pmcc_pclk  input  1  pclk driven by PMCC
sh  output  1  arbitrated shift/load strobe to transmitter/receiver
pclk  output  1  arbitrated shift clock to transmitter/receiver
busy  output  1  sequencer owns sh/pclk
done  output  1  one-cycle pulse on normal completion
aborted  output  1  one-cycle pulse on abort completion
remaining  output  CNT_W  shift pulses not yet issued

Behaviour:
- Everything is synchronous to clk; rst forces all state in one cycle, whatever the current state.
- Reset values: state IDLE; seq_sh=0; seq_pclk=0; busy=0; done=0; aborted=0; remaining=0.
- States: IDLE, LOAD_HI, LOAD_LO, SHIFT_HI, SHIFT_LO, FINISH.
- IDLE: start && !pmcc_busy captures load_en, shift_count and max(half_period,1) into registers, sets busy.
  - Next state is LOAD_HI if load_en, else SHIFT_HI if shift_count != 0, else FINISH.
  - start while pmcc_busy=1 is ignored, with no pulse.
  - start while busy=1 is ignored.
- Timing: internal seq_sh/seq_pclk and busy are registered, so the first edge on pins appears 1 cycle after start is accepted.
- LOAD_HI: seq_sh=1, seq_pclk=1 for H cycles, then LOAD_LO.
- LOAD_LO: seq_sh=1, seq_pclk=0 for H cycles, then SHIFT_HI if count != 0, else FINISH.
- SHIFT_HI: seq_sh=0, seq_pclk=1 for H cycles. remaining decrements on the last cycle of SHIFT_HI.
- SHIFT_LO: seq_pclk=0 for H cycles, then SHIFT_HI if remaining != 0, else FINISH.
- FINISH: seq_sh=0, seq_pclk=0, done=1 for exactly one cycle, busy=0 next cycle, back to IDLE.
- The divider counter reloads to H-1 on every state entry. Total busy cycles = 2H·(N + load_en) + 1.
- remaining equals shift_count at acceptance and reaches 0 when the last pclk high phase ends. It is not wrapped and not decremented below 0.
- abort (any non-IDLE state): next cycle seq_sh=0, seq_pclk=0, aborted=1 for one cycle, busy=0, state IDLE. remaining keeps its value for diagnostics.
  - abort in IDLE is ignored.
  - abort on the same cycle as start: abort has priority and start is dropped.
  - abort on the FINISH cycle: done wins and aborted is not raised.
- Arbitration (combinational mux after the registers): sh = busy ? seq_sh : pmcc_sh; pclk = busy ? seq_pclk : pmcc_pclk.
- The PMCC-side signals pass through with zero latency while idle.
- Max shift_count = 2^CNT_W−1.

Decomposition:
- Shared package pmc_pkg gains the state enum typedef pmc_seq_state_t and localparam defaults PMC_SEQ_CNT_W and PMC_SEQ_DIV_W.
- One natural sub-module: pmc_seq_clkdiv, a loadable down-counter that issues a tick when it reaches 0.
- The FSM, counters and output mux stay in the top module.

Test Plan:
- Reset, then idle with pmcc_sh=1, pmcc_pclk toggling -> sh=1 and pclk mirror the PMCC inputs, busy=0, remaining=0.
- start, load_en=0, shift_count=4, half_period=2 -> 4 pclk pulses, each 2 high / 2 low; sh=0; busy high for 17 cycles; done one cycle; remaining steps 4,3,2,1,0.
- start, load_en=1, shift_count=2, half_period=0 -> one pulse with sh=1 (H=1), then 2 pulses with sh=0; busy for 7 cycles; done asserted.
- start, shift_count=0, load_en=0 -> busy for 1 cycle, done pulse, pclk never rises.
- start with shift_count=100, then abort after 10 cycles -> pclk/sh low next cycle, aborted=1, done never, remaining=95 held. Also start while pmcc_busy=1 -> no response, busy stays 0.
- rst asserted mid-SHIFT_HI -> next cycle pclk=pmcc_pclk, busy=0, no done/aborted pulse. Also abort coincident with start -> nothing starts.

Source files
------------

// File: rtl/pmc_pkg.sv
// pmc_pkg: shared state type and width defaults for the PMC shift sequencer
package pmc_pkg;
  localparam int PMC_SEQ_CNT_W = 16;
  localparam int PMC_SEQ_DIV_W = 8;
  typedef enum logic [2:0] {
    IDLE,
    LOAD_HI,
    LOAD_LO,
    SHIFT_HI,
    SHIFT_LO,
    FINISH
  } pmc_seq_state_t;
endpackage

// File: rtl/pmc_seq_clkdiv.sv
// pmc_seq_clkdiv: loadable down-counter that ticks while it sits at zero
module pmc_seq_clkdiv #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         tick
);
  logic [W-1:0] cnt;
  always_ff @(posedge clk) begin
    if (rst) cnt <= '0;
    else if (load) cnt <= load_val;
    else if (cnt != '0) cnt <= cnt - 1'b1;
  end
  assign tick = cnt == '0;
endmodule

// File: rtl/pmc_shift_sequencer.sv
// pmc_shift_sequencer: sh/pclk load-and-shift sequencer arbitrated against the PMCC
module pmc_shift_sequencer
  import pmc_pkg::*;
#(
  parameter int CNT_W = PMC_SEQ_CNT_W,
  parameter int DIV_W = PMC_SEQ_DIV_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             load_en,
  input  logic [CNT_W-1:0] shift_count,
  input  logic [DIV_W-1:0] half_period,
  input  logic             pmcc_busy,
  input  logic             pmcc_sh,
  input  logic             pmcc_pclk,
  output logic             sh,
  output logic             pclk,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic [CNT_W-1:0] remaining
);
  pmc_seq_state_t state, state_nx;
  logic [DIV_W-1:0] h_reg, h_in, load_val;
  logic [CNT_W-1:0] rem_nx;
  logic seq_sh, seq_pclk, go, tick, div_load, kill;
  assign h_in = (half_period == '0) ? DIV_W'(1) : half_period;
  assign go = (state == IDLE) && start && !pmcc_busy && !abort;
  assign kill = abort && (state != IDLE) && (state != FINISH);
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:     if (go) state_nx = load_en ? LOAD_HI : (shift_count != '0) ? SHIFT_HI : FINISH;
      LOAD_HI:  if (tick) state_nx = LOAD_LO;
      LOAD_LO:  if (tick) state_nx = (remaining != '0) ? SHIFT_HI : FINISH;
      SHIFT_HI: if (tick) state_nx = SHIFT_LO;
      SHIFT_LO: if (tick) state_nx = (remaining != '0) ? SHIFT_HI : FINISH;
      FINISH:   state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
    if (kill) state_nx = IDLE;
  end
  assign rem_nx = go ? shift_count :
                  (state == SHIFT_HI && tick && !kill && remaining != '0) ? remaining - 1'b1 :
                  remaining;
  assign div_load = (state_nx != state) || (state == IDLE);
  assign load_val = ((state == IDLE) ? h_in : h_reg) - 1'b1;
  pmc_seq_clkdiv #(.W(DIV_W)) u_div (
    .clk      (clk),
    .rst      (rst),
    .load     (div_load),
    .load_val (load_val),
    .tick     (tick)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      h_reg     <= DIV_W'(1);
      remaining <= '0;
      seq_sh    <= 1'b0;
      seq_pclk  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      aborted   <= 1'b0;
    end else begin
      state     <= state_nx;
      h_reg     <= go ? h_in : h_reg;
      remaining <= rem_nx;
      seq_sh    <= (state_nx == LOAD_HI) || (state_nx == LOAD_LO);
      seq_pclk  <= (state_nx == LOAD_HI) || (state_nx == SHIFT_HI);
      busy      <= state_nx != IDLE;
      done      <= state_nx == FINISH;
      aborted   <= kill;
    end
  end
  assign sh   = busy ? seq_sh : pmcc_sh;
  assign pclk = busy ? seq_pclk : pmcc_pclk;
endmodule

// File: tb/tb_pmc_shift_sequencer.sv
// tb_pmc_shift_sequencer: scoreboard-driven directed checks of the shift sequencer
module tb_pmc_shift_sequencer;
  typedef struct packed {
    logic        busy;
    logic        sh;
    logic        pclk;
    logic        done;
    logic        aborted;
    logic [15:0] rem;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic load_en = 1'b0;
  logic [15:0] shift_count = '0;
  logic [7:0] half_period = '0;
  logic pmcc_busy = 1'b0;
  logic pmcc_sh = 1'b1;
  logic pmcc_pclk = 1'b0;
  logic sh, pclk, busy, done, aborted;
  logic [15:0] remaining;
  vec_t obs;
  vec_t sb[$];
  int n_checks = 0;
  int n_pass = 0;
  pmc_shift_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .abort       (abort),
    .load_en     (load_en),
    .shift_count (shift_count),
    .half_period (half_period),
    .pmcc_busy   (pmcc_busy),
    .pmcc_sh     (pmcc_sh),
    .pmcc_pclk   (pmcc_pclk),
    .sh          (sh),
    .pclk        (pclk),
    .busy        (busy),
    .done        (done),
    .aborted     (aborted),
    .remaining   (remaining)
  );
  always #5 clk = ~clk;
  assign obs = {busy, sh, pclk, done, aborted, remaining};
  task automatic check(input string tag, input vec_t exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask
  function automatic vec_t mk(input logic b, s, p, d, a, input int r);
    vec_t v;
    v.busy = b;
    v.sh = s;
    v.pclk = p;
    v.done = d;
    v.aborted = a;
    v.rem = 16'(r);
    return v;
  endfunction
  task automatic run(input string tag, input int n, h, l, lim, poke);
    int he, t, cnt, p;
    he = (h == 0) ? 1 : h;
    t = 2 * he * (n + l) + 1;
    for (int k = 1; k <= t + 1 && k <= lim; k++) begin
      cnt = 0;
      for (int q = 0; q < n; q++) if ((2 * l + 2 * q + 1) * he < k) cnt++;
      p = (k - 1) / he;
      if (k < t) sb.push_back(mk(1'b1, l != 0 && p < 2, p % 2 == 0, 1'b0, 1'b0, n - cnt));
      else if (k == t) sb.push_back(mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 0));
      else sb.push_back(mk(1'b0, pmcc_sh, pmcc_pclk, 1'b0, 1'b0, 0));
    end
    @(negedge clk);
    start = 1'b1;
    shift_count = 16'(n);
    half_period = 8'(h);
    load_en = l[0];
    for (int k = 1; sb.size() > 0; k++) begin
      @(negedge clk);
      start = (k == poke);
      shift_count = 16'd7;
      load_en = 1'b1;
      check(tag, sb.pop_front());
    end
    start = 1'b0;
    load_en = 1'b0;
  endtask
  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset", mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0));
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      pmcc_pclk = ~pmcc_pclk;
      #1;
      check("idle_pass", mk(1'b0, 1'b1, pmcc_pclk, 1'b0, 1'b0, 0));
    end
    pmcc_pclk = 1'b1;
    run("shift4_h2", 4, 2, 0, 100, 5);
    run("load_n2_h0", 2, 0, 1, 100, 0);
    run("count0", 0, 3, 0, 100, 0);
    run("load_only", 0, 1, 1, 100, 0);
    run("rst_mid", 5, 3, 0, 2, 0);
    pmcc_pclk = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid_out", mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0));
    @(negedge clk);
    check("rst_mid_after", mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0));
    pmcc_busy = 1'b1;
    start = 1'b1;
    shift_count = 16'd3;
    half_period = 8'd1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      start = 1'b0;
      check("pmcc_busy_block", mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0));
    end
    pmcc_busy = 1'b0;
    start = 1'b1;
    abort = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
      check("abort_with_start", mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0));
    end
    pmcc_pclk = 1'b1;
    run("abort_run", 100, 1, 0, 10, 0);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_pulse", mk(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 95));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("abort_hold", mk(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 95));
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_idle", mk(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 95));
    run("finish_abort", 1, 1, 0, 3, 0);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("finish_abort_out", mk(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
